// File: rtl/pi_result_reporter_pkg.sv
// Shared constants, FSM encoding and snapshot layout for the pi result reporter.
// Frame layout: sync byte, 12 payload bytes (MSB first), XOR checksum.
package pi_result_reporter_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         FRAME_LEN     = 14;
  localparam logic [3:0] IDX_SYNC      = 4'd0;
  localparam logic [3:0] IDX_CHK       = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] inner;
    logic [31:0] total;
    logic [31:0] timer;
  } snapshot_t;

  // Frame index 1..12 maps onto snapshot bytes, most significant first.
  function automatic logic [7:0] payload_byte(input logic [95:0] shadow, input logic [3:0] idx);
    logic [95:0] shifted;
    shifted = shadow >> (7'd8 * (7'd12 - {3'b000, idx}));
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/pi_result_reporter_if.sv
// Byte-wide valid/ready stream from the reporter towards the host link (UART TX).
interface pi_result_reporter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/pi_byte_serializer.sv
// Holds the captured snapshot and walks it out one byte per accepted handshake,
// folding each payload byte into the running XOR checksum as it leaves.
module pi_byte_serializer
  import pi_result_reporter_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        capture_i,
  input  snapshot_t                   snapshot_i,
  pi_result_reporter_if.master        tx,
  output logic                        last_accept_o
);

  snapshot_t  shadow_q, shadow_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] chk_q, chk_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       accept;
  logic [3:0] idx_next;

  assign accept        = valid_q & tx.tx_ready;
  assign idx_next      = idx_q + 4'd1;
  assign last_accept_o = accept && (idx_q == IDX_CHK);
  assign tx.tx_data    = data_q;
  assign tx.tx_valid   = valid_q;

  always_comb begin
    shadow_d = shadow_q;
    idx_d    = idx_q;
    chk_d    = chk_q;
    data_d   = data_q;
    valid_d  = valid_q;
    if (capture_i) begin
      shadow_d = snapshot_i;
      idx_d    = IDX_SYNC;
      chk_d    = 8'h00;
      data_d   = SYNC_BYTE;
      valid_d  = 1'b1;
    end else if (accept) begin
      if (idx_q == IDX_CHK) begin
        valid_d = 1'b0;
        idx_d   = IDX_SYNC;
      end else begin
        idx_d = idx_next;
        if (idx_q != IDX_SYNC) chk_d = chk_q ^ data_q;
        // The checksum byte must already include the payload byte leaving now.
        if (idx_next == IDX_CHK) data_d = chk_q ^ data_q;
        else                     data_d = payload_byte(shadow_q, idx_next);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shadow_q <= '0;
      idx_q    <= IDX_SYNC;
      chk_q    <= 8'h00;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      chk_q    <= chk_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: rtl/pi_result_reporter.sv
// Sends one framed, checksummed snapshot of the pi estimator per done assertion.
//   state | meaning
//   IDLE  | waiting for est_done; capture snapshot when it is seen high
//   SEND  | frame bytes streaming out of the serializer
//   HOLD  | frame sent, waiting for est_done to drop before re-arming
module pi_result_reporter
  import pi_result_reporter_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 est_done_i,
  input  logic [31:0]          inner_points_i,
  input  logic [31:0]          total_points_i,
  input  logic [31:0]          timer_i,
  pi_result_reporter_if.master tx,
  output logic                 report_busy_o,
  output logic [CNT_W-1:0]     reports_sent_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   sent_q, sent_d;
  logic               busy_q, busy_d;
  logic               capture;
  logic               last_accept;
  snapshot_t          snapshot;

  assign snapshot       = '{inner: inner_points_i, total: total_points_i, timer: timer_i};
  assign report_busy_o  = busy_q;
  assign reports_sent_o = sent_q;

  pi_byte_serializer #(.SYNC_BYTE(SYNC_BYTE)) u_ser (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .capture_i     (capture),
    .snapshot_i    (snapshot),
    .tx            (tx),
    .last_accept_o (last_accept)
  );

  always_comb begin
    state_d = state_q;
    sent_d  = sent_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (est_done_i) begin
          capture = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (last_accept) begin
          sent_d  = sent_q + CNT_W'(1);
          state_d = est_done_i ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!est_done_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SEND);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      sent_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_pi_result_reporter.sv
// Directed bench for pi_result_reporter; a second instance with a 2-bit counter
// shares the stimulus to exercise counter wrap.
module tb_pi_result_reporter;
  import pi_result_reporter_pkg::*;

  typedef logic [7:0] frame_t [FRAME_LEN];

  logic        clk = 1'b0;
  logic        reset, reset2;
  logic        est_done;
  logic [31:0] inner, total, timer;
  logic        tx_ready;
  logic        busy, busy2;
  logic [15:0] sent;
  logic [1:0]  sent2;
  int          checks = 0;
  int          failures = 0;
  int          cyc;
  int          nvalid;
  frame_t      f1, f2, fa, fb, fc, fd;

  pi_result_reporter_if tx_if ();
  pi_result_reporter_if tx_if2 ();
  assign tx_if.tx_ready  = tx_ready;
  assign tx_if2.tx_ready = tx_ready;

  always #5 clk = ~clk;

  pi_result_reporter dut (
    .clk_i(clk), .reset_i(reset), .est_done_i(est_done),
    .inner_points_i(inner), .total_points_i(total), .timer_i(timer),
    .tx(tx_if), .report_busy_o(busy), .reports_sent_o(sent)
  );

  pi_result_reporter #(.CNT_W(2)) dut2 (
    .clk_i(clk), .reset_i(reset2), .est_done_i(est_done),
    .inner_points_i(inner), .total_points_i(total), .timer_i(timer),
    .tx(tx_if2), .report_busy_o(busy2), .reports_sent_o(sent2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic frame_t build_frame(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
    frame_t      f;
    logic [95:0] p;
    logic [7:0]  x;
    p = {a, b, c};
    x = 8'h00;
    f[0] = 8'hA5;
    for (int i = 0; i < 12; i++) begin
      f[i+1] = p[95-8*i -: 8];
      x      = x ^ f[i+1];
    end
    f[13] = x;
    return f;
  endfunction

  // Receives bytes [first,last) of a frame; returns after the edge accepting the last one.
  task automatic recv(input frame_t exp, input int first, input int last, input bit rnd,
                      input string tag, output int cycles);
    int         idx;
    bit         stall;
    bit         r;
    logic [7:0] held;
    idx = first; stall = 1'b0; held = 8'h00; cycles = 0;
    while (idx < last && cycles < 100) begin
      @(negedge clk);
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tx_ready = r;
      if (tx_if.tx_valid) begin
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        if (stall) chk({tag, "_stable"}, 32'(tx_if.tx_data), 32'(held));
        if (r) begin
          chk($sformatf("%s_b%0d", tag, idx), 32'(tx_if.tx_data), 32'(exp[idx]));
          idx++;
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          held  = tx_if.tx_data;
        end
      end
      @(posedge clk);
      cycles++;
    end
    chk({tag, "_complete"}, 32'(idx), 32'(last));
  endtask

  initial begin
    f1 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h04,
           8'h00, 8'h00, 8'h00, 8'h04, 8'h03};
    f2 = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hF0, 8'h0D,
           8'h12, 8'h34, 8'h56, 8'h78, 8'hE3};
    fa = build_frame(32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC);
    fb = build_frame(32'h0BAD_F00D, 32'h00C0_FFEE, 32'h1357_9BDF);
    fc = build_frame(32'h0000_0001, 32'h0000_0002, 32'h0000_0100);
    fd = build_frame(32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF);

    reset = 1'b1; reset2 = 1'b1; est_done = 1'b0; tx_ready = 1'b0;
    inner = '0; total = '0; timer = '0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(tx_if.tx_data), 32'h00);
    chk("rst_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sent", 32'(sent), 32'd0);
    chk("rst_sent2", 32'(sent2), 32'd0);
    reset = 1'b0; reset2 = 1'b0;
    @(negedge clk);

    // 1: back-to-back frame with ready held high
    inner = 32'd3; total = 32'd4; timer = 32'd4; est_done = 1'b1;
    recv(f1, 0, FRAME_LEN, 1'b0, "t1", cyc);
    chk("t1_cycles", 32'(cyc), 32'd14);
    @(negedge clk);
    chk("t1_valid_after", 32'(tx_if.tx_valid), 32'd0);
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_sent", 32'(sent), 32'd1);
    chk("t1_sent2", 32'(sent2), 32'd1);
    est_done = 1'b0;
    repeat (2) @(negedge clk);

    // 2: random backpressure
    inner = 32'hDEAD_BEEF; total = 32'hCAFE_F00D; timer = 32'h1234_5678; est_done = 1'b1;
    recv(f2, 0, FRAME_LEN, 1'b1, "t2", cyc);
    @(negedge clk);
    chk("t2_sent", 32'(sent), 32'd2);
    chk("t2_sent2", 32'(sent2), 32'd2);
    est_done = 1'b0;
    repeat (2) @(negedge clk);

    // 3: done held high gives one frame; re-raise gives another
    inner = 32'h0000_0001; total = 32'h0000_0002; timer = 32'h0000_0100; est_done = 1'b1;
    recv(fc, 0, FRAME_LEN, 1'b0, "t3a", cyc);
    nvalid = 0;
    tx_ready = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (tx_if.tx_valid) nvalid++;
    end
    chk("t3_no_refire", 32'(nvalid), 32'd0);
    chk("t3_busy_hold", 32'(busy), 32'd0);
    chk("t3_sent_a", 32'(sent), 32'd3);
    chk("t3_sent2_a", 32'(sent2), 32'd3);
    est_done = 1'b0;
    repeat (2) @(negedge clk);
    inner = 32'h7FFF_FFFF; total = 32'h8000_0000; timer = 32'hFFFF_FFFF; est_done = 1'b1;
    recv(fd, 0, FRAME_LEN, 1'b1, "t3b", cyc);
    @(negedge clk);
    chk("t3_sent_b", 32'(sent), 32'd4);
    chk("t3_sent2_wrap", 32'(sent2), 32'd0);
    est_done = 1'b0;
    repeat (2) @(negedge clk);

    // 4: inputs change and done drops mid-frame
    inner = 32'h1122_3344; total = 32'h5566_7788; timer = 32'h99AA_BBCC; est_done = 1'b1;
    recv(fa, 0, 5, 1'b0, "t4", cyc);
    #1;
    inner = 32'h0BAD_F00D; total = 32'h00C0_FFEE; timer = 32'h1357_9BDF; est_done = 1'b0;
    recv(fa, 5, FRAME_LEN, 1'b0, "t4", cyc);
    #1;
    chk("t4_valid_after", 32'(tx_if.tx_valid), 32'd0);
    chk("t4_sent", 32'(sent), 32'd5);
    chk("t4_sent2", 32'(sent2), 32'd1);
    est_done = 1'b1;
    // Capture on the very next edge proves the FSM went straight back to IDLE.
    recv(fb, 0, 7, 1'b0, "t5a", cyc);
    chk("t4_idle_after_chk", 32'(cyc), 32'd8);

    // 5: reset mid-frame, done still high
    #1;
    reset = 1'b1; tx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_valid_rst", 32'(tx_if.tx_valid), 32'd0);
    chk("t5_busy_rst", 32'(busy), 32'd0);
    chk("t5_sent_rst", 32'(sent), 32'd0);
    chk("t5_dut2_midframe", 32'(tx_if2.tx_valid), 32'd1);
    reset = 1'b0;
    recv(fb, 0, FRAME_LEN, 1'b0, "t5b", cyc);
    chk("t5_cycles", 32'(cyc), 32'd14);
    @(negedge clk);
    chk("t5_valid_after", 32'(tx_if.tx_valid), 32'd0);
    chk("t5_sent", 32'(sent), 32'd1);
    chk("t5_sent2", 32'(sent2), 32'd2);
    est_done = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
